// File: rtl/flag_register_bank.sv
// flag_register_bank: CHANNELS signed WIDTH-bit registers with load/inc/dec/add,
// optional saturation, sticky per-channel overflow flags and a registered read port.
//
// Ports:
//   clk, reset_n           clock, synchronous active-low reset
//   op_valid, op, ch_sel   write strobe, opcode (load/inc/dec/add), target channel
//   data                   load value or signed add step
//   rd_sel                 read channel; rd_data + negative/positive/zero one cycle later
//   ovf_flags, ovf_clr     sticky overflow flags and their per-bit clear mask
//   op_err                 one-cycle pulse after a write to a nonexistent channel
module flag_register_bank #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2,
    parameter bit SATURATE = 1'b1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                op_valid,
    input  logic [1:0]          op,
    input  logic [SEL_W-1:0]    ch_sel,
    input  logic [WIDTH-1:0]    data,
    input  logic [SEL_W-1:0]    rd_sel,
    output logic [WIDTH-1:0]    rd_data,
    output logic                negative,
    output logic                positive,
    output logic                zero,
    output logic [CHANNELS-1:0] ovf_flags,
    input  logic [CHANNELS-1:0] ovf_clr,
    output logic                op_err
);

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_INC  = 2'b01;
    localparam logic [1:0] OP_DEC  = 2'b10;
    localparam logic [1:0] OP_ADD  = 2'b11;

    localparam logic [SEL_W:0]   CH_LIM = (SEL_W+1)'(CHANNELS);
    localparam logic [WIDTH-1:0] MAX_V  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_V  = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0]    regs_q [CHANNELS];
    logic [WIDTH-1:0]    regs_d [CHANNELS];
    logic [CHANNELS-1:0] ovf_q, ovf_d;
    logic [WIDTH-1:0]    rd_q;
    logic                neg_q, pos_q, zero_q, err_q;

    logic             sel_ok, wr_en, ovf;
    logic [WIDTH-1:0] cur, rd_val, res;
    logic [WIDTH:0]   step, sum;

    assign sel_ok = {1'b0, ch_sel} < CH_LIM;
    assign wr_en  = op_valid && sel_ok;

    // Explicit muxes keep out-of-range selects reading as zero.
    always_comb begin
        cur    = '0;
        rd_val = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (ch_sel == SEL_W'(i)) cur    = regs_q[i];
            if (rd_sel == SEL_W'(i)) rd_val = regs_q[i];
        end
    end

    // Sign-extended sum; overflow when the two top bits disagree.
    always_comb begin
        step = '0;
        case (op)
            OP_INC:  step = (WIDTH+1)'(1);
            OP_DEC:  step = '1;
            OP_ADD:  step = {data[WIDTH-1], data};
            default: step = '0;
        endcase
        sum = {cur[WIDTH-1], cur} + step;
        ovf = (op != OP_LOAD) && (sum[WIDTH] != sum[WIDTH-1]);
        if (op == OP_LOAD)
            res = data;
        else if (ovf && SATURATE)
            res = sum[WIDTH] ? MIN_V : MAX_V;
        else
            res = sum[WIDTH-1:0];
    end

    // Set is applied after clear so a same-cycle set wins.
    always_comb begin
        regs_d = regs_q;
        ovf_d  = ovf_q & ~ovf_clr;
        for (int i = 0; i < CHANNELS; i++) begin
            if (wr_en && ch_sel == SEL_W'(i)) begin
                regs_d[i] = res;
                if (ovf) ovf_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            regs_q <= '{default: '0};
            ovf_q  <= '0;
            rd_q   <= '0;
            neg_q  <= 1'b0;
            pos_q  <= 1'b0;
            zero_q <= 1'b1;
            err_q  <= 1'b0;
        end else begin
            regs_q <= regs_d;
            ovf_q  <= ovf_d;
            rd_q   <= rd_val;
            neg_q  <= rd_val[WIDTH-1];
            pos_q  <= !rd_val[WIDTH-1] && (|rd_val);
            zero_q <= ~|rd_val;
            err_q  <= op_valid && !sel_ok;
        end
    end

    assign rd_data   = rd_q;
    assign negative  = neg_q;
    assign positive  = pos_q;
    assign zero      = zero_q;
    assign ovf_flags = ovf_q;
    assign op_err    = err_q;

endmodule

// File: tb/tb_flag_register_bank.sv
// tb_flag_register_bank: three bank configurations (saturating, wrapping,
// 3-channel) driven in parallel and checked against an integer reference model.
module tb_flag_register_bank;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       op_valid = 1'b0;
    logic [1:0] op = 2'b00;
    logic [1:0] ch_sel = 2'b00;
    logic [7:0] data = 8'h00;
    logic [1:0] rd_sel = 2'b00;
    logic [3:0] ovf_clr = 4'b0000;

    always #5 clk = ~clk;

    logic [7:0] rd0, rd1, rd2;
    logic       n0, n1, n2, p0, p1, p2, z0, z1, z2, e0, e1, e2;
    logic [3:0] f0, f1;
    logic [2:0] f2;

    flag_register_bank #(.SATURATE(1'b1)) u_sat (
        .clk(clk), .reset_n(reset_n), .op_valid(op_valid), .op(op),
        .ch_sel(ch_sel), .data(data), .rd_sel(rd_sel), .rd_data(rd0),
        .negative(n0), .positive(p0), .zero(z0), .ovf_flags(f0),
        .ovf_clr(ovf_clr), .op_err(e0)
    );
    flag_register_bank #(.SATURATE(1'b0)) u_wrap (
        .clk(clk), .reset_n(reset_n), .op_valid(op_valid), .op(op),
        .ch_sel(ch_sel), .data(data), .rd_sel(rd_sel), .rd_data(rd1),
        .negative(n1), .positive(p1), .zero(z1), .ovf_flags(f1),
        .ovf_clr(ovf_clr), .op_err(e1)
    );
    flag_register_bank #(.CHANNELS(3), .SATURATE(1'b1)) u_inv (
        .clk(clk), .reset_n(reset_n), .op_valid(op_valid), .op(op),
        .ch_sel(ch_sel), .data(data), .rd_sel(rd_sel), .rd_data(rd2),
        .negative(n2), .positive(p2), .zero(z2), .ovf_flags(f2),
        .ovf_clr(ovf_clr[2:0]), .op_err(e2)
    );

    logic [7:0] rd_o [3];
    logic [2:0] cls_o [3];
    logic [3:0] ovf_o [3];
    logic       err_o [3];

    always_comb begin
        rd_o[0] = rd0; rd_o[1] = rd1; rd_o[2] = rd2;
        cls_o[0] = {n0, p0, z0};
        cls_o[1] = {n1, p1, z1};
        cls_o[2] = {n2, p2, z2};
        ovf_o[0] = f0; ovf_o[1] = f1; ovf_o[2] = {1'b0, f2};
        err_o[0] = e0; err_o[1] = e1; err_o[2] = e2;
    end

    // Reference model: plain integers per instance.
    int         NCH [3] = '{4, 4, 3};
    bit         SAT [3] = '{1'b1, 1'b0, 1'b1};
    int         mreg [3][4];
    int         mrd [3];
    bit [3:0]   movf [3];
    bit         merr [3];
    int         checks = 0;
    int         errors = 0;

    task automatic model_edge();
        int n, old, sd, v;
        if (!reset_n) begin
            for (int k = 0; k < 3; k++) begin
                for (int c = 0; c < 4; c++) mreg[k][c] = 0;
                mrd[k] = 0; movf[k] = '0; merr[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                n = NCH[k];
                mrd[k]  = (int'(rd_sel) < n) ? mreg[k][rd_sel] : 0;
                merr[k] = op_valid && (int'(ch_sel) >= n);
                for (int c = 0; c < n; c++)
                    if (ovf_clr[c]) movf[k][c] = 1'b0;
                if (op_valid && int'(ch_sel) < n) begin
                    old = mreg[k][ch_sel];
                    sd  = int'(signed'(data));
                    case (op)
                        2'd0: v = sd;
                        2'd1: v = old + 1;
                        2'd2: v = old - 1;
                        default: v = old + sd;
                    endcase
                    if (v > 127) begin
                        movf[k][ch_sel] = 1'b1;
                        v = SAT[k] ? 127 : v - 256;
                    end else if (v < -128) begin
                        movf[k][ch_sel] = 1'b1;
                        v = SAT[k] ? -128 : v + 256;
                    end
                    mreg[k][ch_sel] = v;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_op(input logic [1:0] o, input logic [1:0] ch,
                         input logic [7:0] d);
        op_valid = 1'b1; op = o; ch_sel = ch; data = d;
        step();
        op_valid = 1'b0;
    endtask

    task automatic read(input logic [1:0] rs);
        rd_sel = rs;
        step();
    endtask

    task automatic rand_inputs();
        logic [7:0] picks [5];
        picks[0] = 8'h7F; picks[1] = 8'h80; picks[2] = 8'h01;
        picks[3] = 8'hFF; picks[4] = 8'($urandom);
        op_valid = ($urandom_range(0, 3) != 0);
        op       = 2'($urandom);
        ch_sel   = 2'($urandom);
        data     = picks[$urandom_range(0, 4)];
        rd_sel   = 2'($urandom);
        ovf_clr  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 12; i++) begin
            rand_inputs();
            step();
        end
        reset_n = 1'b0;
        op_valid = 1'b1; op = 2'b01; ch_sel = 2'd0;
        step();
        step();
        reset_n = 1'b1;
        op_valid = 1'b0; ovf_clr = '0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rd_o[k] !== 8'h00 || cls_o[k] !== 3'b001 ||
                ovf_o[k] !== 4'b0 || err_o[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset inst%0d: rd=%h npz=%b ovf=%b err=%b want 00 001 0000 0",
                         k, rd_o[k], cls_o[k], ovf_o[k], err_o[k]);
            end
        end
        for (int c = 0; c < 4; c++) begin
            read(2'(c));
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (rd_o[k] !== 8'h00 || cls_o[k] !== 3'b001) begin
                    errors++;
                    $display("FAIL reset_read inst%0d ch%0d: rd=%h npz=%b want 00 001",
                             k, c, rd_o[k], cls_o[k]);
                end
            end
        end
    endtask

    task automatic test_load_classify();
        logic [7:0] ev [4];
        logic [2:0] ec [4];
        ev[1] = 8'h3F; ev[2] = 8'h40; ev[3] = 8'h80;
        ec[1] = 3'b010; ec[2] = 3'b010; ec[3] = 3'b100;
        do_op(2'b00, 2'd1, 8'h3F);
        do_op(2'b00, 2'd2, 8'h40);
        do_op(2'b00, 2'd3, 8'h80);
        for (int c = 1; c < 4; c++) begin
            read(2'(c));
            checks++;
            if (rd_o[0] !== ev[c] || cls_o[0] !== ec[c]) begin
                errors++;
                $display("FAIL load_classify ch%0d: rd=%h npz=%b want %h %b",
                         c, rd_o[0], cls_o[0], ev[c], ec[c]);
            end
        end
        do_op(2'b10, 2'd0, 8'h00);
        read(2'd0);
        checks++;
        if (rd_o[0] !== 8'hFF || cls_o[0] !== 3'b100 || ovf_o[0][0] !== 1'b0) begin
            errors++;
            $display("FAIL dec_from_zero: rd=%h npz=%b ovf0=%b want ff 100 0",
                     rd_o[0], cls_o[0], ovf_o[0][0]);
        end
    endtask

    task automatic test_saturation();
        do_op(2'b00, 2'd0, 8'h7E);
        repeat (3) do_op(2'b01, 2'd0, 8'h00);
        read(2'd0);
        checks++;
        if (rd_o[0] !== 8'h7F || cls_o[0] !== 3'b010 || ovf_o[0][0] !== 1'b1) begin
            errors++;
            $display("FAIL sat_max: rd=%h npz=%b ovf0=%b want 7f 010 1",
                     rd_o[0], cls_o[0], ovf_o[0][0]);
        end
        do_op(2'b00, 2'd1, 8'h80);
        do_op(2'b11, 2'd1, 8'h80);
        read(2'd1);
        checks++;
        if (rd_o[0] !== 8'h80 || ovf_o[0][1] !== 1'b1) begin
            errors++;
            $display("FAIL sat_min: rd=%h ovf1=%b want 80 1", rd_o[0], ovf_o[0][1]);
        end
    endtask

    task automatic test_wrap();
        ovf_clr = 4'b1111;
        step();
        ovf_clr = 4'b0000;
        do_op(2'b00, 2'd2, 8'h7F);
        do_op(2'b01, 2'd2, 8'h00);
        read(2'd2);
        checks++;
        if (rd_o[1] !== 8'h80 || cls_o[1] !== 3'b100 || ovf_o[1][2] !== 1'b1) begin
            errors++;
            $display("FAIL wrap_max: rd=%h npz=%b ovf2=%b want 80 100 1",
                     rd_o[1], cls_o[1], ovf_o[1][2]);
        end
        do_op(2'b00, 2'd2, 8'h7F);
        ovf_clr = 4'b0100;
        do_op(2'b01, 2'd2, 8'h00);
        ovf_clr = 4'b0000;
        checks++;
        if (ovf_o[1][2] !== 1'b1) begin
            errors++;
            $display("FAIL set_wins: ovf2=%b want 1", ovf_o[1][2]);
        end
        ovf_clr = 4'b0100;
        step();
        ovf_clr = 4'b0000;
        checks++;
        if (ovf_o[1][2] !== 1'b0) begin
            errors++;
            $display("FAIL clear: ovf2=%b want 0", ovf_o[1][2]);
        end
        do_op(2'b00, 2'd0, 8'h80);
        do_op(2'b10, 2'd0, 8'h00);
        read(2'd0);
        checks++;
        if (rd_o[1] !== 8'h7F || cls_o[1] !== 3'b010 || ovf_o[1][0] !== 1'b1) begin
            errors++;
            $display("FAIL wrap_min: rd=%h npz=%b ovf0=%b want 7f 010 1",
                     rd_o[1], cls_o[1], ovf_o[1][0]);
        end
    endtask

    task automatic test_read_before_write();
        rd_sel = 2'd3;
        do_op(2'b00, 2'd3, 8'h05);
        do_op(2'b00, 2'd3, 8'h10);
        checks++;
        if (rd_o[0] !== 8'h05) begin
            errors++;
            $display("FAIL rbw_old: rd=%h want 05", rd_o[0]);
        end
        step();
        checks++;
        if (rd_o[0] !== 8'h10) begin
            errors++;
            $display("FAIL rbw_new: rd=%h want 10", rd_o[0]);
        end
    endtask

    task automatic test_invalid();
        logic [7:0] ev [3];
        ev[0] = 8'h11; ev[1] = 8'h22; ev[2] = 8'h33;
        ovf_clr = 4'b1111;
        step();
        ovf_clr = 4'b0000;
        for (int c = 0; c < 3; c++) do_op(2'b00, 2'(c), ev[c]);
        do_op(2'b11, 2'd3, 8'h7F);
        checks++;
        if (err_o[2] !== 1'b1 || err_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL op_err_pulse: inv=%b sat=%b want 1 0", err_o[2], err_o[0]);
        end
        step();
        checks++;
        if (err_o[2] !== 1'b0) begin
            errors++;
            $display("FAIL op_err_clear: inv=%b want 0", err_o[2]);
        end
        for (int c = 0; c < 3; c++) begin
            read(2'(c));
            checks++;
            if (rd_o[2] !== ev[c]) begin
                errors++;
                $display("FAIL invalid_keep ch%0d: rd=%h want %h", c, rd_o[2], ev[c]);
            end
        end
        read(2'd3);
        checks++;
        if (rd_o[2] !== 8'h00 || cls_o[2] !== 3'b001 || ovf_o[2] !== 4'b0) begin
            errors++;
            $display("FAIL invalid_read: rd=%h npz=%b ovf=%b want 00 001 0000",
                     rd_o[2], cls_o[2], ovf_o[2]);
        end
    endtask

    task automatic test_random();
        logic [2:0] ec;
        for (int i = 0; i < 1500; i++) begin
            rand_inputs();
            reset_n = ($urandom_range(0, 60) != 0);
            step();
            for (int k = 0; k < 3; k++) begin
                ec = {mrd[k] < 0, mrd[k] > 0, mrd[k] == 0};
                checks++;
                if (rd_o[k] !== 8'(mrd[k]) || cls_o[k] !== ec) begin
                    errors++;
                    $display("FAIL rand_read inst%0d cyc%0d: rd=%h npz=%b want %h %b",
                             k, i, rd_o[k], cls_o[k], 8'(mrd[k]), ec);
                end
                checks++;
                if (ovf_o[k] !== movf[k] || err_o[k] !== merr[k]) begin
                    errors++;
                    $display("FAIL rand_flags inst%0d cyc%0d: ovf=%b err=%b want %b %b",
                             k, i, ovf_o[k], err_o[k], movf[k], merr[k]);
                end
            end
        end
        reset_n = 1'b1;
        op_valid = 1'b0;
        ovf_clr = '0;
    endtask

    initial begin
        step();
        step();
        reset_n = 1'b1;
        test_reset();
        test_load_classify();
        test_saturation();
        test_wrap();
        test_read_before_write();
        test_invalid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
